// File: rtl/spi_master_pkg.sv
// Shared types and mode-0 pin idle levels for the SPI initiator.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP,
    DONE
  } state_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_master_shreg.sv
// Transmit/receive shift-register pair. The tx register advances on sclk rising
// events so its MSB already holds the next bit when the falling event updates mosi.
module spi_master_shreg #(
  parameter int NBITS = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_load_data,
  input  logic             i_tx_shift,
  input  logic             i_rx_shift,
  input  logic             i_serial_in,
  output logic             o_serial_out,
  output logic [NBITS-1:0] o_rx_data
);

  logic [NBITS-1:0] r_tx;
  logic [NBITS-1:0] r_rx;
  logic [NBITS-1:0] w_tx_shifted;
  logic [NBITS-1:0] w_rx_shifted;

  generate
    if (NBITS > 1) begin : g_multi
      assign w_tx_shifted = {r_tx[NBITS-2:0], 1'b0};
      assign w_rx_shifted = {r_rx[NBITS-2:0], i_serial_in};
    end else begin : g_single
      assign w_tx_shifted = '0;
      assign w_rx_shifted = i_serial_in;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_load_data;
      end else if (i_tx_shift) begin
        r_tx <= w_tx_shifted;
      end
      if (i_rx_shift) begin
        r_rx <= w_rx_shifted;
      end
    end
  end

  assign o_serial_out = r_tx[NBITS-1];
  assign o_rx_data    = r_rx;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one NBITS frame per accepted request, captured miso
// bits returned as a val/rdy response that must drain before the next request.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int NBITS   = 34,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_val,
  output logic             send_rdy,
  input  logic [NBITS-1:0] send_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic [NBITS-1:0] recv_msg,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             busy
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  state_t           r_state;
  logic [DW-1:0]    r_div_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_cs;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_recv_val;
  logic [NBITS-1:0] r_recv_msg;

  logic             w_timed;
  logic             w_div_last;
  logic             w_load;
  logic             w_tx_shift;
  logic             w_rx_shift;
  logic             w_tx_msb;
  logic [NBITS-1:0] w_rx_data;

  assign w_timed    = (r_state != IDLE) && (r_state != DONE);
  assign w_div_last = w_timed && (r_div_cnt == DIV_LAST);
  assign w_load     = (r_state == IDLE) && send_val;
  assign w_tx_shift = w_div_last && ((r_state == SETUP) || (r_state == SHIFT_LO));
  assign w_rx_shift = w_div_last && (r_state == SHIFT_HI);

  spi_master_shreg #(
    .NBITS(NBITS)
  ) u_shreg (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_data (send_msg),
    .i_tx_shift  (w_tx_shift),
    .i_rx_shift  (w_rx_shift),
    .i_serial_in (miso),
    .o_serial_out(w_tx_msb),
    .o_rx_data   (w_rx_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_cs       <= CS_IDLE;
      r_sclk     <= SCLK_IDLE;
      r_mosi     <= MOSI_IDLE;
      r_recv_val <= 1'b0;
      r_recv_msg <= '0;
    end else begin
      // Every timed state exits on the last divider count, so wrapping here
      // is the same as clearing on each state change.
      if (w_timed) begin
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + DIV_ONE;
      end else begin
        r_div_cnt <= '0;
      end

      case (r_state)
        IDLE: begin
          if (send_val) begin
            r_cs    <= 1'b0;
            r_mosi  <= send_msg[NBITS-1];
            r_state <= SETUP;
          end
        end
        SETUP, SHIFT_LO: begin
          if (w_div_last) begin
            r_sclk  <= 1'b1;
            r_state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (w_div_last) begin
            r_sclk    <= SCLK_IDLE;
            r_bit_cnt <= r_bit_cnt + BIT_ONE;
            if (r_bit_cnt == BIT_LAST) begin
              r_mosi  <= MOSI_IDLE;
              r_state <= HOLD;
            end else begin
              r_mosi  <= w_tx_msb;
              r_state <= SHIFT_LO;
            end
          end
        end
        HOLD: begin
          if (w_div_last) begin
            r_cs    <= CS_IDLE;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_div_last) begin
            r_recv_msg <= w_rx_data;
            r_recv_val <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (recv_rdy) begin
            r_recv_val <= 1'b0;
            r_bit_cnt  <= '0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign send_rdy = (r_state == IDLE) && !reset;
  assign busy     = (r_state != IDLE);
  assign recv_val = r_recv_val;
  assign recv_msg = r_recv_msg;
  assign cs       = r_cs;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 34-bit/div-2 instance (loopback or mode-0
// minion model on miso) and a 1-bit/div-1 instance for the minimal frame.
module tb_spi_master;

  localparam int NB = 34;
  localparam int CD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          send_val_a, send_rdy_a, recv_val_a, recv_rdy_a;
  logic          cs_a, sclk_a, mosi_a, miso_a, busy_a;
  logic [NB-1:0] send_msg_a, recv_msg_a;

  logic       send_val_b, send_rdy_b, recv_val_b, recv_rdy_b;
  logic       cs_b, sclk_b, mosi_b, miso_b, busy_b;
  logic [0:0] send_msg_b, recv_msg_b;

  spi_master #(.NBITS(NB), .CLK_DIV(CD)) dut_a (
    .clk(clk), .reset(reset),
    .send_val(send_val_a), .send_rdy(send_rdy_a), .send_msg(send_msg_a),
    .recv_val(recv_val_a), .recv_rdy(recv_rdy_a), .recv_msg(recv_msg_a),
    .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .busy(busy_a)
  );

  spi_master #(.NBITS(1), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset),
    .send_val(send_val_b), .send_rdy(send_rdy_b), .send_msg(send_msg_b),
    .recv_val(recv_val_b), .recv_rdy(recv_rdy_b), .recv_msg(recv_msg_b),
    .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .busy(busy_b)
  );

  // Mode-0 minion: presents resp MSB-first, advances on sclk falling edges.
  logic          use_minion;
  logic [NB-1:0] m_resp;
  logic [NB-1:0] m_cap = '0;
  int            m_bit = 0;
  logic          minion_bit;
  assign minion_bit = (m_bit < NB) ? m_resp[NB-1-m_bit] : 1'b0;
  assign miso_a     = use_minion ? minion_bit : mosi_a;

  always @(negedge sclk_a or posedge cs_a) begin
    if (cs_a) m_bit <= 0;
    else      m_bit <= m_bit + 1;
  end

  int   sclk_rises = 0;
  logic mosi_at_rise_b = 1'b0;
  always @(posedge sclk_a) begin
    m_cap      <= {m_cap[NB-2:0], mosi_a};
    sclk_rises <= sclk_rises + 1;
  end
  always @(posedge sclk_b) mosi_at_rise_b <= mosi_b;

  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  int   mosi_viol = 0;
  int   gap_run   = 0;
  int   last_gap  = 0;
  always @(negedge clk) begin
    if (sclk_a && prev_sclk && (mosi_a !== prev_mosi)) mosi_viol <= mosi_viol + 1;
    prev_sclk <= sclk_a;
    prev_mosi <= mosi_a;
    if (cs_a) begin
      gap_run <= gap_run + 1;
    end else begin
      if (gap_run != 0) last_gap <= gap_run;
      gap_run <= 0;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one packet on dut_a and returns at the negedge where recv_val is first seen.
  task automatic run_frame(input logic [NB-1:0] msg, output logic [NB-1:0] got,
                           output int lows, output int lat, output int rises);
    int k, t_fall, t_rv, r0;
    k = 0;
    while (!send_rdy_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("pre_send_rdy", send_rdy_a, 1);
    r0 = sclk_rises;
    send_val_a = 1'b1;
    send_msg_a = msg;
    @(negedge clk);
    send_val_a = 1'b0;
    send_msg_a = ~msg;
    k = 0; t_fall = -1; t_rv = -1; lows = 0;
    while (t_rv < 0 && k < 1000) begin
      if (!cs_a) begin
        lows++;
        if (t_fall < 0) t_fall = k;
      end
      if (recv_val_a) t_rv = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
    got   = recv_msg_a;
    lat   = (t_rv < 0) ? -1 : t_rv - t_fall;
    rises = sclk_rises - r0;
  endtask

  task automatic ack_a();
    recv_rdy_a = 1'b1;
    @(negedge clk);
    recv_rdy_a = 1'b0;
  endtask

  typedef struct {
    logic [NB-1:0] msg;
    logic          minion;
    logic [NB-1:0] resp;
    logic [NB-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] got, p1, p2, g0, g1;
    int lows, lat, rises, bad, nrecv, k, r0, rv_seen;
    logic [2:0] pins_pre;

    vecs[0] = '{34'h2_DEAD_BEEF, 1'b0, 34'h0,         34'h2_DEAD_BEEF};
    vecs[1] = '{34'h3_0000_FFFF, 1'b1, 34'h1_2345_6789, 34'h1_2345_6789};
    vecs[2] = '{34'h0_0000_0000, 1'b0, 34'h0,         34'h0_0000_0000};
    vecs[3] = '{34'h3_FFFF_FFFF, 1'b0, 34'h0,         34'h3_FFFF_FFFF};
    vecs[4] = '{34'h2_AAAA_5555, 1'b1, 34'h1_2345_6789, 34'h1_2345_6789};
    vecs[5] = '{34'h1_0000_0001, 1'b1, 34'h2_8000_0001, 34'h2_8000_0001};

    reset = 1'b1;
    send_val_a = 1'b0; send_msg_a = '0; recv_rdy_a = 1'b0;
    send_val_b = 1'b0; send_msg_b = '0; recv_rdy_b = 1'b0; miso_b = 1'b0;
    use_minion = 1'b0; m_resp = '0;
    repeat (3) @(negedge clk);

    chk("reset_pins_a", {cs_a, sclk_a, mosi_a, recv_val_a, send_rdy_a, busy_a}, 6'b100000);
    chk("reset_recv_msg_a", recv_msg_a, 0);
    chk("reset_pins_b", {cs_b, sclk_b, mosi_b, recv_val_b, send_rdy_b, busy_b}, 6'b100000);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_send_rdy", send_rdy_a, 1);

    for (int i = 0; i < 6; i++) begin
      use_minion = vecs[i].minion;
      m_resp     = vecs[i].resp;
      run_frame(vecs[i].msg, got, lows, lat, rises);
      chk($sformatf("v%0d_recv_msg", i), got, vecs[i].exp);
      chk($sformatf("v%0d_cs_low", i), lows, 138);
      chk($sformatf("v%0d_latency", i), lat, 140);
      chk($sformatf("v%0d_sclk_rises", i), rises, 34);
      if (vecs[i].minion) chk($sformatf("v%0d_minion_cap", i), m_cap, vecs[i].msg);
      $display("vec %0d: sent %h recv %h cs_low %0d lat %0d rises %0d", i, vecs[i].msg, got, lows, lat, rises);
      ack_a();
      chk($sformatf("v%0d_ack_clear", i), recv_val_a, 0);
    end

    // Response backpressure with an ignored request pulse.
    use_minion = 1'b0;
    run_frame(34'h1_5A5A_0F0F, got, lows, lat, rises);
    chk("bp_recv_msg", got, 34'h1_5A5A_0F0F);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 20) begin send_val_a = 1'b1; send_msg_a = 34'h2_2222_2222; end
      if (c == 21) send_val_a = 1'b0;
      if (!recv_val_a || recv_msg_a !== 34'h1_5A5A_0F0F || send_rdy_a || !cs_a || !busy_a) bad++;
    end
    chk("bp_stable", bad, 0);
    ack_a();
    chk("bp_ack_val", recv_val_a, 0);
    chk("bp_ack_rdy", send_rdy_a, 1);
    $display("backpressure: held 50 cycles, unstable samples %0d", bad);

    // Back-to-back frames with send_val held high.
    p1 = 34'h0_1234_5678; p2 = 34'h3_8765_4321; g0 = '0; g1 = '0; nrecv = 0;
    recv_rdy_a = 1'b1; send_val_a = 1'b1; send_msg_a = p1;
    k = 0;
    while (nrecv < 2 && k < 1000) begin
      @(negedge clk);
      k++;
      if (busy_a && send_msg_a == p1) send_msg_a = p2;
      if (recv_val_a) begin
        if (nrecv == 0) g0 = recv_msg_a; else g1 = recv_msg_a;
        nrecv++;
        if (nrecv == 2) send_val_a = 1'b0;
      end
    end
    send_val_a = 1'b0;
    @(negedge clk);
    recv_rdy_a = 1'b0;
    chk("b2b_count", nrecv, 2);
    chk("b2b_first", g0, p1);
    chk("b2b_second", g1, p2);
    chk("b2b_gap_ge3", (last_gap >= 3), 1);
    $display("back-to-back: recv %h then %h, cs gap %0d", g0, g1, last_gap);

    // Minimal frame: NBITS=1, CLK_DIV=1, miso 0 then 1.
    for (int j = 0; j < 2; j++) begin
      miso_b = j[0];
      k = 0;
      while (!send_rdy_b && k < 20) begin @(negedge clk); k++; end
      send_val_b = 1'b1; send_msg_b = 1'b1;
      @(negedge clk);
      send_val_b = 1'b0; send_msg_b = 1'b0;
      lows = 0; k = 0;
      while (!recv_val_b && k < 50) begin
        if (!cs_b) lows++;
        @(negedge clk);
        k++;
      end
      chk($sformatf("b%0d_recv_val", j), recv_val_b, 1);
      chk($sformatf("b%0d_cs_low", j), lows, 3);
      chk($sformatf("b%0d_recv_msg", j), recv_msg_b, j[0]);
      chk($sformatf("b%0d_mosi_at_rise", j), mosi_at_rise_b, 1);
      $display("nbits1 %0d: miso %0d recv %0d cs_low %0d", j, j, recv_msg_b, lows);
      recv_rdy_b = 1'b1;
      @(negedge clk);
      recv_rdy_b = 1'b0;
    end

    // Reset in the middle of bit 11's high phase.
    send_val_a = 1'b1; send_msg_a = 34'h3_FFFF_FFFF;
    r0 = sclk_rises;
    @(negedge clk);
    send_val_a = 1'b0;
    k = 0;
    while (!((sclk_rises - r0) >= 11 && sclk_a) && k < 400) begin
      @(negedge clk);
      k++;
    end
    pins_pre = {cs_a, sclk_a, mosi_a};
    chk("midrst_pre_pins", pins_pre, 3'b011);
    reset = 1'b1;
    #1;
    chk("midrst_pins", {cs_a, sclk_a, mosi_a}, 3'b100);
    chk("midrst_rdy_busy", {send_rdy_a, busy_a}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (recv_val_a) rv_seen++;
    end
    chk("midrst_no_recv_val", rv_seen, 0);
    run_frame(34'h2_4680_1357, got, lows, lat, rises);
    chk("post_rst_recv", got, 34'h2_4680_1357);
    chk("post_rst_cs_low", lows, 138);
    chk("post_rst_latency", lat, 140);
    $display("reset mid-frame: recovered frame recv %h", got);
    ack_a();

    chk("mosi_stable_in_high", mosi_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
